core_launcher: RTL and testbench



---
 rtl/core_pkg.sv | 28 ++
 rtl/core_launcher_if.sv | 27 ++
 rtl/core_launcher_run_counter.sv | 39 +++
 rtl/core_launcher.sv | 140 ++++++++++++++
 tb/tb_core_launcher.sv | 359 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared types and constants for the core launcher and its run counter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package core_pkg;

  localparam int CORE_ADDR_W = 32;
  localparam int CORE_DATA_W = 32;
  localparam int CNT_W       = 32;

  // Low address bits an instruction beat must carry to be written.
  localparam logic [1:0] ALIGN_MASK = 2'b00;

  localparam logic [CNT_W-1:0] MAX_CYCLES_DEF = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SETPC = 3'd2,
    WAKE  = 3'd3,
    RUN   = 3'd4,
    DONE  = 3'd5
  } launchState_t;

  function automatic logic isAligned(input logic [1:0] lowBits);
    return lowBits == ALIGN_MASK;
  endfunction

endpackage

// File: rtl/core_launcher_if.sv
// Host program-beat stream (address/word/last) into the launcher.
// Latency: n/a (wires only).
// Backpressure: valid/ready; a beat moves when host_valid and host_ready are both high.
interface core_launcher_if
  import core_pkg::*;
#(
  parameter int ADDR_W = CORE_ADDR_W,
  parameter int DATA_W = CORE_DATA_W
) ();

  logic              host_valid;
  logic              host_ready;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_data;
  logic              host_last;

  modport master (
    output host_valid, host_addr, host_data, host_last,
    input  host_ready
  );

  modport slave (
    input  host_valid, host_addr, host_data, host_last,
    output host_ready
  );

endinterface

// File: rtl/core_launcher_run_counter.sv
// Saturating run-cycle counter with clear, enable and limit-hit flag.
// Latency: count updates on the clock edge; limitHit is combinational for the current cycle.
// Backpressure: none.
module run_counter
  import core_pkg::*;
#(
  parameter logic [CNT_W-1:0] LIMIT = MAX_CYCLES_DEF
) (
  input  logic             sclk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             limitHit
);

  logic [CNT_W-1:0] nextCount;

  // Next value saturates at LIMIT; the hit flag reports that this cycle's increment reaches it.
  always_comb begin
    nextCount = count;
    if (en && (count < LIMIT)) begin
      nextCount = count + 1'b1;
    end
    limitHit = en && (nextCount >= LIMIT);
  end

  // Counter register; clear beats enable so a fresh run always starts at zero.
  always_ff @(posedge sclk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else begin
      count <= nextCount;
    end
  end

endmodule

// File: rtl/core_launcher.sv
// Loads a program into the core RAM, then forces PC, wakes the core and times the run.
// Latency: accepted beat is written one cycle later; start -> SETPC -> WAKE -> RUN, one cycle each.
// Backpressure: host_ready high only in IDLE/LOAD; start is ignored outside IDLE.
module core_launcher
  import core_pkg::*;
#(
  parameter logic [CNT_W-1:0] MAX_CYCLES = MAX_CYCLES_DEF,
  parameter int               ADDR_W     = CORE_ADDR_W,
  parameter int               DATA_W     = CORE_DATA_W
) (
  input  logic                  sclk,
  input  logic                  reset,
  core_launcher_if.slave        host,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     start_pc,
  input  logic                  done_ack,
  output logic                  load,
  output logic [ADDR_W-1:0]     loadAddress,
  output logic [DATA_W-1:0]     loadInstruction,
  output logic [ADDR_W-1:0]     PCOut,
  output logic                  PCLoad,
  output logic                  wake,
  output logic                  RegRuntime,
  input  logic                  CPUExit,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout,
  output logic                  align_err,
  output logic [CNT_W-1:0]      cycle_count
);

  launchState_t state;
  logic         lastPending;
  logic         beatTaken;
  logic         startTaken;
  logic         limitHit;

  assign host.host_ready = (state == IDLE) || (state == LOAD);
  assign busy            = (state != IDLE);
  assign beatTaken       = host.host_valid && host.host_ready;
  // A beat in the same cycle wins over start.
  assign startTaken      = start && (state == IDLE) && !beatTaken;

  run_counter #(
    .LIMIT (MAX_CYCLES)
  ) u_run_counter (
    .sclk     (sclk),
    .reset    (reset),
    .clr      (startTaken),
    .en       (state == RUN),
    .count    (cycle_count),
    .limitHit (limitHit)
  );

  // Launch sequencer: state plus every registered strobe and status flag.
  always_ff @(posedge sclk) begin
    if (reset) begin
      state           <= IDLE;
      lastPending     <= 1'b0;
      load            <= 1'b0;
      loadAddress     <= '0;
      loadInstruction <= '0;
      PCOut           <= '0;
      PCLoad          <= 1'b0;
      wake            <= 1'b0;
      RegRuntime      <= 1'b0;
      done            <= 1'b0;
      timeout         <= 1'b0;
      align_err       <= 1'b0;
    end else begin
      load   <= 1'b0;
      PCLoad <= 1'b0;
      wake   <= 1'b0;
      if (beatTaken) begin
        // Misaligned beats are consumed so the stream keeps moving, but never written.
        state       <= LOAD;
        lastPending <= host.host_last;
        if (isAligned(host.host_addr[1:0])) begin
          load            <= 1'b1;
          loadAddress     <= host.host_addr;
          loadInstruction <= host.host_data;
        end else begin
          align_err <= 1'b1;
        end
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state      <= SETPC;
              PCOut      <= start_pc;
              PCLoad     <= 1'b1;
              RegRuntime <= 1'b1;
              done       <= 1'b0;
              timeout    <= 1'b0;
              align_err  <= 1'b0;
            end
          end
          LOAD: begin
            if (lastPending) begin
              state       <= IDLE;
              lastPending <= 1'b0;
            end
          end
          SETPC: begin
            state      <= WAKE;
            wake       <= 1'b1;
            RegRuntime <= 1'b1;
          end
          WAKE: begin
            state <= RUN;
          end
          RUN: begin
            // Exit on the limit cycle is a clean finish, not a timeout.
            if (CPUExit) begin
              state      <= DONE;
              done       <= 1'b1;
              RegRuntime <= 1'b0;
              timeout    <= 1'b0;
            end else if (limitHit) begin
              state      <= DONE;
              done       <= 1'b1;
              RegRuntime <= 1'b0;
              timeout    <= 1'b1;
            end
          end
          DONE: begin
            if (done_ack || start) begin
              state <= IDLE;
              done  <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_core_launcher.sv
// Randomized bench for core_launcher with a transaction-level reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_core_launcher;
  import core_pkg::*;

  localparam logic [31:0] MAXC = 32'd10;

  logic        sclk = 1'b0;
  logic        reset, start, done_ack, CPUExit;
  logic [31:0] start_pc;
  logic        load, PCLoad, wake, RegRuntime, busy, done, timeout, align_err;
  logic [31:0] loadAddress, loadInstruction, PCOut, cycle_count;

  core_launcher_if hif ();

  core_launcher #(.MAX_CYCLES(MAXC)) dut (
    .sclk(sclk), .reset(reset), .host(hif), .start(start), .start_pc(start_pc),
    .done_ack(done_ack), .load(load), .loadAddress(loadAddress),
    .loadInstruction(loadInstruction), .PCOut(PCOut), .PCLoad(PCLoad), .wake(wake),
    .RegRuntime(RegRuntime), .CPUExit(CPUExit), .busy(busy), .done(done),
    .timeout(timeout), .align_err(align_err), .cycle_count(cycle_count)
  );

  always #5 sclk = ~sclk;

  int total = 0;
  int bad = 0;
  bit alignExp;
  logic [31:0] bAddr[$];
  logic [31:0] bData[$];

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic add_beat(input logic [31:0] a, input logic [31:0] d);
    bAddr.push_back(a);
    bData.push_back(d);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    total++;
    if ({load, PCLoad, wake, RegRuntime, busy, done, timeout, align_err} !== 8'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b want=%b",
               {load, PCLoad, wake, RegRuntime, busy, done, timeout, align_err}, 8'b0);
    end
    total++;
    if (hif.host_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready got=%b want=1", hif.host_ready);
    end
    total++;
    if ({cycle_count, PCOut, loadAddress, loadInstruction} !== 128'b0) begin
      bad++;
      $display("FAIL reset_buses got=%h/%h/%h/%h want=0", cycle_count, PCOut, loadAddress, loadInstruction);
    end
    reset = 1'b0;
    alignExp = 1'b0;
    tick();
  endtask

  // Streams the queued beats with random idle gaps; every accepted aligned beat must
  // appear on the load port exactly one cycle later.
  task automatic drive_beats(input int maxGap);
    bit aligned;
    for (int i = 0; i < bAddr.size(); i++) begin
      int gap;
      gap = $urandom_range(0, maxGap);
      repeat (gap) begin
        hif.host_valid = 1'b0;
        tick();
        total++;
        if ({load, busy} !== {1'b0, (i > 0)}) begin
          bad++;
          $display("FAIL gap_state got=%b want=%b", {load, busy}, {1'b0, (i > 0)});
        end
      end
      hif.host_valid = 1'b1;
      hif.host_addr  = bAddr[i];
      hif.host_data  = bData[i];
      hif.host_last  = (i == bAddr.size() - 1);
      total++;
      if (hif.host_ready !== 1'b1) begin
        bad++;
        $display("FAIL beat_ready got=%b want=1", hif.host_ready);
      end
      tick();
      aligned = (bAddr[i][1:0] == 2'b00);
      if (!aligned) alignExp = 1'b1;
      total++;
      if (load !== aligned) begin
        bad++;
        $display("FAIL beat_load addr=%h got=%b want=%b", bAddr[i], load, aligned);
      end
      if (aligned) begin
        total++;
        if ({loadAddress, loadInstruction} !== {bAddr[i], bData[i]}) begin
          bad++;
          $display("FAIL beat_data got=%h/%h want=%h/%h", loadAddress, loadInstruction, bAddr[i], bData[i]);
        end
      end
      total++;
      if ({busy, align_err} !== {1'b1, alignExp}) begin
        bad++;
        $display("FAIL beat_status got=%b want=%b", {busy, align_err}, {1'b1, alignExp});
      end
    end
    hif.host_valid = 1'b0;
    hif.host_last  = 1'b0;
    tick();
    total++;
    if ({load, busy, hif.host_ready} !== 3'b001) begin
      bad++;
      $display("FAIL load_exit got=%b want=001", {load, busy, hif.host_ready});
    end
    bAddr.delete();
    bData.delete();
  endtask

  // One launch from IDLE. exitCycle is the RUN cycle carrying CPUExit (0 = never).
  task automatic run_launch(input logic [31:0] pc, input int exitCycle, input bit pokeStart, input bit ackWithStart);
    int expEnd;
    bit expTo;
    expTo  = (exitCycle == 0) || (exitCycle > int'(MAXC));
    expEnd = expTo ? int'(MAXC) : exitCycle;
    start = 1'b1;
    start_pc = pc;
    CPUExit = 1'($urandom_range(0, 1));
    tick();
    start = 1'b0;
    alignExp = 1'b0;
    total++;
    if ({PCLoad, wake, RegRuntime, busy, done, timeout, align_err} !== 7'b1011000 || PCOut !== pc) begin
      bad++;
      $display("FAIL setpc got=%b pc=%h want=1011000 pc=%h",
               {PCLoad, wake, RegRuntime, busy, done, timeout, align_err}, PCOut, pc);
    end
    total++;
    if (cycle_count !== 32'd0) begin
      bad++;
      $display("FAIL setpc_count got=%0d want=0", cycle_count);
    end
    CPUExit = 1'b1;
    start_pc = ~pc;
    tick();
    total++;
    if ({PCLoad, wake, RegRuntime, busy, done} !== 5'b01110 || PCOut !== pc) begin
      bad++;
      $display("FAIL wake got=%b pc=%h want=01110 pc=%h", {PCLoad, wake, RegRuntime, busy, done}, PCOut, pc);
    end
    CPUExit = 1'($urandom_range(0, 1));
    tick();
    total++;
    if ({PCLoad, wake, RegRuntime, done} !== 4'b0010 || cycle_count !== 32'd0) begin
      bad++;
      $display("FAIL run_entry got=%b cnt=%0d want=0010 cnt=0", {PCLoad, wake, RegRuntime, done}, cycle_count);
    end
    for (int k = 1; k <= expEnd; k++) begin
      CPUExit = (k == exitCycle);
      start = pokeStart && (k == 2);
      tick();
      start = 1'b0;
      if (k < expEnd) begin
        total++;
        if ({RegRuntime, done, PCLoad, busy} !== 4'b1001 || cycle_count !== 32'(k)) begin
          bad++;
          $display("FAIL run_cycle k=%0d got=%b cnt=%0d want=1001 cnt=%0d",
                   k, {RegRuntime, done, PCLoad, busy}, cycle_count, k);
        end
      end
    end
    CPUExit = 1'b0;
    total++;
    if ({done, timeout, RegRuntime, busy, hif.host_ready} !== {1'b1, expTo, 1'b0, 1'b1, 1'b0}
        || cycle_count !== 32'(expEnd)) begin
      bad++;
      $display("FAIL done_state got=%b cnt=%0d want=%b cnt=%0d", {done, timeout, RegRuntime, busy, hif.host_ready},
               cycle_count, {1'b1, expTo, 1'b0, 1'b1, 1'b0}, expEnd);
    end
    repeat (2) begin
      CPUExit = 1'($urandom_range(0, 1));
      tick();
    end
    CPUExit = 1'b0;
    total++;
    if (done !== 1'b1 || cycle_count !== 32'(expEnd)) begin
      bad++;
      $display("FAIL done_hold got=%b cnt=%0d want=1 cnt=%0d", done, cycle_count, expEnd);
    end
    if (ackWithStart) start = 1'b1;
    else done_ack = 1'b1;
    tick();
    start = 1'b0;
    done_ack = 1'b0;
    total++;
    if ({done, busy, PCLoad, timeout} !== {3'b000, expTo} || cycle_count !== 32'(expEnd)) begin
      bad++;
      $display("FAIL done_exit got=%b cnt=%0d want=%b cnt=%0d", {done, busy, PCLoad, timeout},
               cycle_count, {3'b000, expTo}, expEnd);
    end
    tick();
    total++;
    if ({PCLoad, busy, wake} !== 3'b000) begin
      bad++;
      $display("FAIL no_relaunch got=%b want=000", {PCLoad, busy, wake});
    end
  endtask

  task automatic test_load();
    add_beat(32'h0, 32'hAAAA_0001);
    add_beat(32'h4, 32'hBBBB_0002);
    add_beat(32'h8, 32'hCCCC_0003);
    drive_beats(0);
  endtask

  task automatic test_align();
    add_beat(32'h6, 32'hDEAD_0006);
    add_beat(32'hC, 32'hBEEF_000C);
    drive_beats(0);
    total++;
    if (align_err !== 1'b1) begin
      bad++;
      $display("FAIL align_sticky got=%b want=1", align_err);
    end
  endtask

  task automatic test_start_ignored();
    hif.host_valid = 1'b1;
    hif.host_addr  = 32'h100;
    hif.host_data  = 32'h1234_5678;
    hif.host_last  = 1'b0;
    tick();
    hif.host_valid = 1'b0;
    start = 1'b1;
    start_pc = 32'h80;
    tick();
    start = 1'b0;
    total++;
    if ({PCLoad, busy, load} !== 3'b010) begin
      bad++;
      $display("FAIL start_in_load got=%b want=010", {PCLoad, busy, load});
    end
    hif.host_valid = 1'b1;
    hif.host_addr  = 32'h104;
    hif.host_last  = 1'b1;
    tick();
    hif.host_valid = 1'b0;
    hif.host_last  = 1'b0;
    tick();
    total++;
    if ({busy, PCLoad, wake} !== 3'b000) begin
      bad++;
      $display("FAIL load_then_idle got=%b want=000", {busy, PCLoad, wake});
    end
    hif.host_valid = 1'b1;
    hif.host_addr  = 32'h200;
    hif.host_data  = 32'h0BAD_F00D;
    hif.host_last  = 1'b1;
    start = 1'b1;
    start_pc = 32'h90;
    tick();
    hif.host_valid = 1'b0;
    hif.host_last  = 1'b0;
    start = 1'b0;
    total++;
    if ({load, PCLoad, busy} !== 3'b101 || loadAddress !== 32'h200) begin
      bad++;
      $display("FAIL start_with_beat got=%b addr=%h want=101 addr=200", {load, PCLoad, busy}, loadAddress);
    end
    tick();
    total++;
    if ({busy, PCLoad, wake, RegRuntime} !== 4'b0000) begin
      bad++;
      $display("FAIL start_with_beat_after got=%b want=0000", {busy, PCLoad, wake, RegRuntime});
    end
    run_launch(32'h0000_0500, 6, 1'b1, 1'b0);
  endtask

  task automatic test_reset_midrun();
    start = 1'b1;
    start_pc = 32'h300;
    tick();
    start = 1'b0;
    CPUExit = 1'b0;
    tick();
    tick();
    repeat (3) tick();
    total++;
    if (cycle_count !== 32'd3 || RegRuntime !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset got cnt=%0d rt=%b want cnt=3 rt=1", cycle_count, RegRuntime);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if ({load, PCLoad, wake, RegRuntime, busy, done, timeout, align_err} !== 8'b0
        || {cycle_count, PCOut, loadAddress, loadInstruction} !== 128'b0 || hif.host_ready !== 1'b1) begin
      bad++;
      $display("FAIL midrun_reset flags=%b cnt=%0d pc=%h ready=%b want all 0, ready=1",
               {load, PCLoad, wake, RegRuntime, busy, done, timeout, align_err}, cycle_count, PCOut, hif.host_ready);
    end
    alignExp = 1'b0;
    CPUExit = 1'b1;
    repeat (3) tick();
    CPUExit = 1'b0;
    total++;
    if ({done, busy, RegRuntime} !== 3'b000) begin
      bad++;
      $display("FAIL exit_after_reset got=%b want=000", {done, busy, RegRuntime});
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int n;
      n = $urandom_range(1, 4);
      for (int b = 0; b < n; b++) begin
        logic [31:0] a;
        a = 32'($urandom_range(0, 255)) << 2;
        if ($urandom_range(0, 3) == 0) a = a + 32'($urandom_range(1, 3));
        add_beat(a, $urandom);
      end
      drive_beats(2);
      run_launch(32'($urandom_range(0, 1023)) << 2, $urandom_range(0, 13),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    done_ack = 1'b0;
    CPUExit = 1'b0;
    start_pc = 32'h0;
    hif.host_valid = 1'b0;
    hif.host_addr  = 32'h0;
    hif.host_data  = 32'h0;
    hif.host_last  = 1'b0;
    test_reset();
    test_load();
    test_align();
    run_launch(32'h40, 5, 1'b0, 1'b0);
    run_launch(32'h44, 0, 1'b0, 1'b1);
    run_launch(32'h48, int'(MAXC), 1'b0, 1'b0);
    test_start_ignored();
    test_reset_midrun();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
